// File: rtl/mult_stream_pkg.sv
// Shared widths and default timing/depth for the unsigned multiplier stream block.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mult_stream_pkg;

  localparam int OPERAND_W   = 32;
  localparam int PRODUCT_W   = 64;
  localparam int MUL_LATENCY = 2;
  localparam int FIFO_DEPTH  = 4;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [PRODUCT_W-1:0] product_t;

endpackage

// File: rtl/mult32u_normal_ripple_wrapper.sv
// Registered 32x32 unsigned multiplier: operands captured, then product registered.
// Latency: 2 clock edges from operand sample to product on the output.
// Backpressure: none; it samples every cycle, the controller decides which results matter.
// Ports: clk; multiplicand/multiplier in (32b); product out (64b).
module mult32u_normal_ripple_wrapper (
  input  logic        clk,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [63:0] product
);

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_p;

  // Pure datapath: no reset, validity is tracked by the controller.
  always_ff @(posedge clk) begin
    r_a <= multiplicand;
    r_b <= multiplier;
    r_p <= 64'(r_a) * 64'(r_b);
  end

  assign product = r_p;

endmodule

// File: rtl/mult_result_fifo.sv
// Fall-through result FIFO: head entry visible on rd_data whenever count != 0.
// Latency: a write at edge E is visible on rd_data in the cycle after E.
// Backpressure: none internally; the writer must never write when full (asserted).
// Ports: clk, rst_n; wr_en/wr_data write side; pop/rd_data read side; count occupancy.
module mult_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   pop,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_full;

  assign w_do_pop = pop && (r_count != '0);
  assign w_full   = (r_count == CW'(DEPTH));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en)    r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({wr_en, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left unreset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

  // The controller's credit check must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && w_full));

endmodule

// File: rtl/mult32u_stream_ctrl.sv
// Valid/ready front end for a registered multiplier, buffering products in a result FIFO.
// Latency: 3 cycles in-to-out (fire at E0, FIFO write at E0+MUL_LATENCY, visible next cycle).
// Backpressure: in_ready drops when buffered + in-flight results would exceed FIFO_DEPTH.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b upstream; mul_* to/from multiplier;
//        out_valid/out_ready/out_product downstream; ops_done pop counter.
module mult32u_stream_ctrl #(
  parameter int MUL_LATENCY = mult_stream_pkg::MUL_LATENCY,
  parameter int FIFO_DEPTH  = mult_stream_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] mul_multiplicand,
  output logic [31:0] mul_multiplier,
  input  logic [63:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic [31:0] ops_done
);

  import mult_stream_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [MUL_LATENCY-1:0] r_vld_sr;
  logic [31:0]            r_ops_done;
  logic [CW-1:0]          w_fifo_count;
  logic [CW-1:0]          w_inflight;
  logic [CW:0]            w_occupancy;
  logic                   w_fire;
  logic                   w_pop;
  logic                   w_wr;
  product_t               w_fifo_head;
  operand_t               w_a;
  operand_t               w_b;

  // Operands go straight to the multiplier; only accepted pairs are tracked.
  assign w_a              = in_a;
  assign w_b              = in_b;
  assign mul_multiplicand = w_a;
  assign mul_multiplier   = w_b;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_vld_sr[i]);
    end
  end

  // Every accepted pair owns a FIFO slot from the moment it fires. A pop in the
  // same cycle is not credited, which keeps in_ready off the out_ready path.
  assign w_occupancy = {1'b0, w_fifo_count} + {1'b0, w_inflight};
  assign in_ready    = rst_n && (w_occupancy < (CW+1)'(FIFO_DEPTH));
  assign w_fire      = in_valid && in_ready;
  assign w_wr        = r_vld_sr[MUL_LATENCY-1];
  assign out_valid   = (w_fifo_count != '0);
  assign w_pop       = out_valid && out_ready;

  // Clearing the shift register on reset is what keeps stale multiplier
  // contents from ever being written after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr   <= '0;
      r_ops_done <= '0;
    end else begin
      r_vld_sr <= (r_vld_sr << 1) | MUL_LATENCY'(w_fire);
      if (w_pop) r_ops_done <= r_ops_done + 32'd1;
    end
  end

  assign ops_done = r_ops_done;

  mult_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PRODUCT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr),
    .wr_data (mul_product),
    .pop     (w_pop),
    .rd_data (w_fifo_head),
    .count   (w_fifo_count)
  );

  assign out_product = w_fifo_head;

endmodule
